// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Sends one command byte to
//                the keyboard over open-collector PS2C/PS2D drive enables,
//                with input filtering, odd parity, ack check and watchdogs.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYC  = 3000,
    parameter int START_TO_CYC = 375000,
    parameter int BIT_TO_CYC   = 5000
) (
    input  logic       clk,
    input  logic       RSTN,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code
);

    // One shared counter serves the inhibit timer and every watchdog, so it
    // is sized for the largest of the three limits.
    localparam int c_MAX_AB  = (INHIBIT_CYC > START_TO_CYC) ? INHIBIT_CYC : START_TO_CYC;
    localparam int c_CNT_MAX = (c_MAX_AB > BIT_TO_CYC) ? c_MAX_AB : BIT_TO_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_INH_LAST   = c_CNT_W'(INHIBIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_TO_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST   = c_CNT_W'(BIT_TO_CYC - 1);

    localparam logic [1:0] c_ERR_OK      = 2'b00;
    localparam logic [1:0] c_ERR_NOACK   = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INHIBIT   = 4'd1,
        S_REQ       = 4'd2,
        S_WAIT_DEV  = 4'd3,
        S_SEND      = 4'd4,
        S_ACK       = 4'd5,
        S_LINE_IDLE = 4'd6,
        S_FAIL      = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    logic [1:0]         r_c_sync;
    logic [1:0]         r_d_sync;
    logic [3:0]         r_c_hist;
    logic [3:0]         r_d_hist;
    logic               r_c_filt;
    logic               r_d_filt;
    logic               r_fall;

    state_t             r_state;
    logic [9:0]         r_sh;
    logic [3:0]         r_bitcnt;
    logic [c_CNT_W-1:0] r_cnt;

    // Synchronize both pins, then accept a new level only after four equal
    // samples; the fall pulse lines up with the filtered clock dropping.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
            r_c_hist <= 4'hF;
            r_d_hist <= 4'hF;
            r_c_filt <= 1'b1;
            r_d_filt <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_c_sync <= {r_c_sync[0], ps2c_in};
            r_d_sync <= {r_d_sync[0], ps2d_in};
            r_c_hist <= {r_c_hist[2:0], r_c_sync[1]};
            r_d_hist <= {r_d_hist[2:0], r_d_sync[1]};
            if (r_c_hist == 4'h0) begin
                r_c_filt <= 1'b0;
            end else if (r_c_hist == 4'hF) begin
                r_c_filt <= 1'b1;
            end
            if (r_d_hist == 4'h0) begin
                r_d_filt <= 1'b0;
            end else if (r_d_hist == 4'hF) begin
                r_d_filt <= 1'b1;
            end
            r_fall <= r_c_filt & (r_c_hist == 4'h0);
        end
    end

    // Transaction sequencer; all pin enables and status are registered here.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= S_IDLE;
            r_sh     <= '0;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= c_ERR_OK;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    if (tx_start) begin
                        // Frame after the start bit: data LSB first, odd parity, stop.
                        r_sh     <= {1'b1, ~^tx_data, tx_data};
                        err_code <= c_ERR_OK;
                        busy     <= 1'b1;
                        ps2c_oe  <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt == c_INH_LAST) begin
                        ps2d_oe <= 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    // Release the clock, keep the start bit on data.
                    ps2c_oe <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT_DEV;
                end
                S_WAIT_DEV: begin
                    if (r_fall) begin
                        ps2d_oe  <= ~r_sh[0];
                        r_sh     <= {1'b1, r_sh[9:1]};
                        r_bitcnt <= 4'd1;
                        r_cnt    <= '0;
                        r_state  <= S_SEND;
                    end else if (r_cnt == c_START_LAST) begin
                        ps2d_oe  <= 1'b0;
                        err_code <= c_ERR_TIMEOUT;
                        r_state  <= S_FAIL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (r_fall) begin
                        ps2d_oe  <= ~r_sh[0];
                        r_sh     <= {1'b1, r_sh[9:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_cnt    <= '0;
                        // The fall seen with bitcnt 9 is edge 10: stop bit released.
                        if (r_bitcnt == 4'd9) begin
                            r_state <= S_ACK;
                        end
                    end else if (r_cnt == c_BIT_LAST) begin
                        ps2d_oe  <= 1'b0;
                        err_code <= c_ERR_TIMEOUT;
                        r_state  <= S_FAIL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (r_fall) begin
                        err_code <= r_d_filt ? c_ERR_NOACK : c_ERR_OK;
                        r_cnt    <= '0;
                        r_state  <= S_LINE_IDLE;
                    end else if (r_cnt == c_BIT_LAST) begin
                        ps2d_oe  <= 1'b0;
                        err_code <= c_ERR_TIMEOUT;
                        r_state  <= S_FAIL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LINE_IDLE: begin
                    if (r_c_filt && r_d_filt) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt == c_BIT_LAST) begin
                        err_code <= c_ERR_TIMEOUT;
                        r_state  <= S_FAIL;
                    end else if (r_fall) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FAIL: begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // A request arriving here is dropped on purpose.
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with a PS/2 device model
//                and a scoreboard checked on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH = 30;
    localparam int STO = 1500;
    localparam int BTO = 200;
    localparam int H   = 40;

    logic       clk      = 1'b0;
    logic       RSTN     = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_c    = 1'b1;
    logic       dev_d    = 1'b1;
    wire        ps2c_in;
    wire        ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    // Open-collector wired-AND of host and device drivers with pull-ups.
    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    always #20 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .START_TO_CYC(STO),
        .BIT_TO_CYC  (BTO)
    ) dut (
        .clk     (clk),
        .RSTN    (RSTN),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .busy    (busy),
        .done    (done),
        .err_code(err_code)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] err;
        bit         chk_rx;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [9:0] dev_bits = '0;
    int         cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (RSTN && done) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got done with empty scoreboard expected none");
                end else begin
                    e = sb.pop_front();
                    check("err_code", err_code, e.err);
                    check("oe_released_at_done", {ps2c_oe, ps2d_oe}, 2'b00);
                    check("busy_low_at_done", busy, 0);
                    if (e.chk_rx) begin
                        check("rx_data", dev_bits[7:0], e.data);
                        check("rx_parity", dev_bits[8], ($countones(e.data) % 2 == 0) ? 1 : 0);
                        check("rx_stop", dev_bits[9], 1);
                    end
                end
            end
        end
    end

    // Device model. mode 0: ack, 1: no ack, 2: never clocks, 3: stop after edge 5.
    task automatic dev_run(input int mode, input bit glitch);
        int n;
        dev_bits = '0;
        n = 0;
        while (!(ps2c_in === 1'b1 && ps2d_in === 1'b0) && n < INH + 100) begin
            @(negedge clk);
            n++;
        end
        check("dev_saw_request", (n < INH + 100) ? 1 : 0, 1);
        if (mode == 2) return;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
                if (mode != 1) dev_d = 1'b0;
                repeat (H / 2) @(negedge clk);
            end
            dev_c = 1'b0;
            repeat (H) @(negedge clk);
            if (mode == 3 && k == 5) return;
            if (k <= 10) dev_bits[k-1] = ps2d_in;
            dev_c = 1'b1;
            if (k == 11) begin
                dev_d = 1'b1;
            end else if (k == 10) begin
                repeat (H / 2) @(negedge clk);
            end else if (glitch && k >= 2) begin
                repeat (H / 2) @(negedge clk);
                dev_c = 1'b0;
                repeat (2) @(negedge clk);
                dev_c = 1'b1;
                repeat (H / 2 - 2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input int mode, input bit glitch,
                        input bit chk_inh, input bit poke_busy, input bit poke_done);
        int   n;
        int   d_at;
        int   t0;
        exp_t e;
        if (mode != 3) begin
            e.data   = b;
            e.err    = (mode == 0) ? 2'b00 : (mode == 1) ? 2'b01 : 2'b10;
            e.chk_rx = (mode < 2);
            sb.push_back(e);
        end
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        t0       = cyc;
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check("busy_after_accept", busy, 1);
        if (chk_inh) begin
            n    = 1;
            d_at = 0;
            while (ps2c_oe === 1'b1 && n < INH + 50) begin
                if (ps2d_oe === 1'b1 && d_at == 0) d_at = n;
                @(negedge clk);
                n++;
            end
            check("clk_inhibit_len", n - 1, INH + 1);
            check("start_bit_cycle", d_at, INH + 1);
        end
        if (poke_busy) begin
            tx_data  = ~b;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
        end
        dev_run(mode, glitch);
        if (mode == 3) return;
        n = 0;
        while (done !== 1'b1 && n < STO + INH + 50) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        if (mode == 2) begin
            check("timeout_latency_ok",
                  ((cyc - t0) >= INH + STO && (cyc - t0) <= INH + STO + 10) ? 1 : 0, 1);
        end
        if (poke_done) begin
            tx_data  = 8'hA5;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            check("start_in_done_ignored", busy, 0);
        end else begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("idle_after_done", {busy, ps2c_oe, ps2d_oe}, 3'b000);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        RSTN = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {ps2c_oe, ps2d_oe, busy, done, err_code}, 6'b000000);
        RSTN = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hF4, 0, 0, 1, 0, 0);
        send(8'hED, 0, 0, 1, 0, 0);
        send(8'h5A, 2, 0, 0, 0, 0);
        check("err_held_after_timeout", err_code, 2'b10);
        send(8'h3C, 1, 0, 0, 0, 0);

        // Abort mid-frame with reset: lines drop without any clock edge.
        send(8'h81, 3, 0, 0, 0, 0);
        #3 RSTN = 1'b0;
        #1 check("reset_midframe_release", {ps2c_oe, ps2d_oe, busy, done}, 4'b0000);
        dev_c = 1'b1;
        dev_d = 1'b1;
        repeat (3) @(negedge clk);
        RSTN = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", busy, 0);
        send(8'hFF, 0, 0, 0, 0, 0);

        send(8'h96, 0, 1, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            rb = 8'($urandom);
            send(rb, ($urandom_range(0, 3) == 0) ? 1 : 0, 1'($urandom), 0, 0, 0);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
